// File: rtl/rr_mux_arbiter_if.sv
// Shared request/data bus between N requesters and the round-robin mux arbiter.
// The master side drives requests and data; the slave (arbiter) returns grant and muxed data.
interface rr_mux_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DW    = 8,
    parameter int unsigned SEL_W = 2
);

    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] din;
    logic [N_REQ-1:0]    gnt;
    logic [SEL_W-1:0]    sel;
    logic [DW-1:0]       dout;
    logic                dout_vld;
    logic                busy;

    modport master (
        output req,
        output din,
        input  gnt,
        input  sel,
        input  dout,
        input  dout_vld,
        input  busy
    );

    modport slave (
        input  req,
        input  din,
        output gnt,
        output sel,
        output dout,
        output dout_vld,
        output busy
    );

endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving an N:1 data mux; grants one owner at a time for up to
// MAX_BURST transfers and registers the selected word onto a single output with a valid flag.
module rr_mux_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DW        = 8,
    parameter int unsigned SEL_W     = 2,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    rr_mux_arbiter_if.slave   bus
);

    localparam int unsigned     CntW    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [SEL_W-1:0] LastIdx = SEL_W'(N_REQ - 1);
    localparam logic [CntW-1:0]  LastCnt = CntW'(MAX_BURST - 1);

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } state_e;

    // Returns {found, index}: first requester at or after start, wrapping modulo N_REQ.
    function automatic logic [SEL_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [SEL_W-1:0] start);
        logic [SEL_W:0]   res;
        logic [SEL_W-1:0] idx;
        res = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = SEL_W'((32'(start) + i) % N_REQ);
            if (!res[SEL_W] && r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    function automatic logic [N_REQ-1:0] one_hot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    state_e            state_q;
    logic [SEL_W-1:0]  ptr_q;
    logic [CntW-1:0]   cnt_q;
    logic [SEL_W-1:0]  sel_q;
    logic [N_REQ-1:0]  gnt_q;
    logic [DW-1:0]     dout_q;
    logic              vld_q;

    logic              granted;
    logic              xfer;
    logic              release_now;
    logic [SEL_W-1:0]  ptr_next;
    logic [SEL_W:0]    pick_idle;
    logic [SEL_W:0]    pick_rel;
    logic [DW-1:0]     word;

    always_comb begin
        granted     = (state_q == StGrant);
        xfer        = granted && bus.req[sel_q];
        release_now = granted && (!bus.req[sel_q] || (cnt_q == LastCnt));
        ptr_next    = (sel_q == LastIdx) ? '0 : sel_q + SEL_W'(1);
        pick_idle   = rr_pick(bus.req, ptr_q);
        // Previous owner drops to lowest priority by scanning from the slot after it.
        pick_rel    = rr_pick(bus.req, ptr_next);
    end

    always_comb begin
        word = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (sel_q == SEL_W'(k)) begin
                word = bus.din[k*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    vld_q <= 1'b0;
                    if (pick_idle[SEL_W]) begin
                        state_q <= StGrant;
                        sel_q   <= pick_idle[SEL_W-1:0];
                        gnt_q   <= one_hot(pick_idle[SEL_W-1:0]);
                        cnt_q   <= '0;
                    end
                end
                StGrant: begin
                    vld_q <= xfer;
                    if (xfer) begin
                        dout_q <= word;
                    end
                    if (release_now) begin
                        ptr_q <= ptr_next;
                        if (pick_rel[SEL_W]) begin
                            sel_q <= pick_rel[SEL_W-1:0];
                            gnt_q <= one_hot(pick_rel[SEL_W-1:0]);
                            cnt_q <= '0;
                        end else begin
                            state_q <= StIdle;
                            gnt_q   <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    gnt_q   <= '0;
                    vld_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.sel      = sel_q;
    assign bus.dout     = dout_q;
    assign bus.dout_vld = vld_q;
    assign bus.busy     = (state_q == StGrant);

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
    a_gnt_matches : assert property (@(posedge clk) disable iff (!rst_n)
                                     (state_q == StGrant) |-> (gnt_q == one_hot(sel_q)));
    a_cnt_bound   : assert property (@(posedge clk) disable iff (!rst_n) (cnt_q <= LastCnt));

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed scenarios plus randomized traffic, all checked against
// a transfer-counting round-robin model.
module tb_rr_mux_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int SW = 2;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_mux_arbiter_if #(.N_REQ(N), .DW(DW), .SEL_W(SW)) bus ();

    rr_mux_arbiter #(
        .N_REQ    (N),
        .DW       (DW),
        .SEL_W    (SW),
        .MAX_BURST(MB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: owner and number of words moved in the current ownership.
    bit          m_busy  = 1'b0;
    int          m_owner = 0;
    int          m_ptr   = 0;
    int          m_count = 0;
    logic [7:0]  m_dout  = '0;
    bit          m_vld   = 1'b0;

    logic [15:0] obs;
    assign obs = {bus.gnt, bus.sel, bus.dout, bus.dout_vld, bus.busy};

    function automatic int choose(input logic [N-1:0] r, input int start);
        for (int i = 0; i < N; i++) begin
            if (r[(start + i) % N]) return (start + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [15:0] expect_vec();
        logic [N-1:0] g;
        g = m_busy ? 4'(1 << m_owner) : 4'b0000;
        return {g, 2'(m_owner), m_dout, m_vld, m_busy};
    endfunction

    task automatic model_step();
        int  k;
        bit  moved;
        if (!rst_n) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_count = 0; m_dout = '0; m_vld = 0;
        end else if (!m_busy) begin
            m_vld = 0;
            k = choose(bus.req, m_ptr);
            if (k >= 0) begin
                m_busy = 1; m_owner = k; m_count = 0;
            end
        end else begin
            moved = bus.req[m_owner];
            m_vld = moved;
            if (moved) begin
                m_dout  = bus.din[m_owner*DW +: DW];
                m_count = m_count + 1;
            end
            if (!moved || m_count == MB) begin
                m_ptr = (m_owner + 1) % N;
                k = choose(bus.req, m_ptr);
                if (k >= 0) begin
                    m_owner = k; m_count = 0;
                end else begin
                    m_busy = 0;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int k, input logic [7:0] v);
        bus.din[k*DW +: DW] = v;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        bus.req = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        bus.req = 4'b1111;
        bus.din = '1;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (obs !== 16'h0000) begin
                bad++;
                $display("FAIL reset c%0d got=%h want=0000", c, obs);
            end
            total++;
            if (obs !== expect_vec()) begin
                bad++;
                $display("FAIL reset_model c%0d got=%h want=%h", c, obs, expect_vec());
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        bus.din = '0;
        bus.req = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            set_word(2, 8'(8'h10 + (i > 0 ? i - 1 : 0)));
            tick();
            total++;
            if (bus.gnt !== 4'b0100 || bus.sel !== 2'd2 || bus.dout_vld !== (i > 0) ||
                (i > 0 && bus.dout !== 8'(8'h0F + i))) begin
                bad++;
                $display("FAIL single e%0d got gnt=%b sel=%0d vld=%b dout=%h want dout=%h",
                         i, bus.gnt, bus.sel, bus.dout_vld, bus.dout, 8'(8'h0F + i));
            end
            total++;
            if (obs !== expect_vec()) begin
                bad++;
                $display("FAIL single_model e%0d got=%h want=%h", i, obs, expect_vec());
            end
        end
        bus.req = 4'b0000;
        tick();
        total++;
        if (bus.busy !== 1'b0 || bus.dout_vld !== 1'b0 || bus.gnt !== 4'b0000 ||
            bus.sel !== 2'd2) begin
            bad++;
            $display("FAIL single_idle got=%h want busy=0 vld=0 gnt=0 sel=2", obs);
        end
    endtask

    task automatic test_contention();
        do_reset();
        bus.req = 4'b1111;
        for (int k = 0; k < N; k++) set_word(k, 8'(8'hA0 + k));
        for (int e = 0; e < 20; e++) begin
            tick();
            total++;
            if (bus.gnt !== 4'(1 << ((e / 4) % 4)) || bus.dout_vld !== (e > 0) ||
                (e > 0 && bus.dout !== 8'(8'hA0 + ((e - 1) / 4) % 4))) begin
                bad++;
                $display("FAIL contention e%0d got gnt=%b vld=%b dout=%h want gnt=%b",
                         e, bus.gnt, bus.dout_vld, bus.dout, 4'(1 << ((e / 4) % 4)));
            end
            total++;
            if (obs !== expect_vec()) begin
                bad++;
                $display("FAIL contention_model e%0d got=%h want=%h", e, obs, expect_vec());
            end
        end
    endtask

    task automatic test_early_drop();
        logic [3:0] want_gnt;
        bit         want_vld;
        logic [7:0] want_dout;
        do_reset();
        for (int e = 0; e < 7; e++) begin
            bus.req = (e < 3) ? 4'b1001 : 4'b1000;
            set_word(0, 8'(8'h30 + e));
            set_word(3, 8'(8'hC0 + e));
            tick();
            want_gnt  = (e < 3) ? 4'b0001 : 4'b1000;
            want_vld  = (e == 1 || e == 2 || e >= 4);
            want_dout = (e >= 4) ? 8'(8'hC0 + e) : 8'(8'h30 + e);
            total++;
            if (bus.gnt !== want_gnt || bus.dout_vld !== want_vld ||
                (want_vld && bus.dout !== want_dout)) begin
                bad++;
                $display("FAIL early_drop e%0d got gnt=%b vld=%b dout=%h want %b %b %h",
                         e, bus.gnt, bus.dout_vld, bus.dout, want_gnt, want_vld, want_dout);
            end
            total++;
            if (obs !== expect_vec()) begin
                bad++;
                $display("FAIL early_drop_model e%0d got=%h want=%h", e, obs, expect_vec());
            end
        end
    endtask

    task automatic test_priority();
        logic [3:0] req_tab [7] = '{4'b1010, 4'b1010, 4'b1010, 4'b1000, 4'b1000, 4'b1000,
                                    4'b0010};
        logic [3:0] gnt_tab [7] = '{4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b1000,
                                    4'b0010};
        do_reset();
        bus.din = 32'h5544_3322;
        for (int e = 0; e < 7; e++) begin
            bus.req = req_tab[e];
            tick();
            total++;
            if (bus.gnt !== gnt_tab[e]) begin
                bad++;
                $display("FAIL priority e%0d got gnt=%b want=%b", e, bus.gnt, gnt_tab[e]);
            end
            total++;
            if (obs !== expect_vec()) begin
                bad++;
                $display("FAIL priority_model e%0d got=%h want=%h", e, obs, expect_vec());
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        bus.req = 4'b1111;
        for (int k = 0; k < N; k++) set_word(k, 8'(8'hA0 + k));
        for (int e = 0; e < 10; e++) tick();
        total++;
        if (bus.gnt !== 4'b0100 || bus.dout !== 8'hA2) begin
            bad++;
            $display("FAIL mid_reset_pre got gnt=%b dout=%h want 0100 a2", bus.gnt, bus.dout);
        end
        rst_n = 1'b0;
        tick();
        total++;
        if (obs !== 16'h0000) begin
            bad++;
            $display("FAIL mid_reset got=%h want=0000", obs);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (bus.gnt !== 4'b0001 || bus.sel !== 2'd0 || bus.busy !== 1'b1 ||
            bus.dout_vld !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_restart got=%h want gnt=0001 sel=0 busy=1 vld=0", obs);
        end
        for (int e = 0; e < 6; e++) begin
            tick();
            total++;
            if (obs !== expect_vec()) begin
                bad++;
                $display("FAIL mid_reset_model e%0d got=%h want=%h", e, obs, expect_vec());
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        bus.req = '0;
        for (int c = 0; c < 400; c++) begin
            rst_n   = ($urandom_range(63) != 0);
            bus.req = bus.req ^ 4'($urandom & $urandom);
            if ($urandom_range(15) == 0) bus.req = '0;
            bus.din = $urandom;
            tick();
            total++;
            if (obs !== expect_vec()) begin
                bad++;
                $display("FAIL random c%0d got=%h want=%h req=%b", c, obs, expect_vec(),
                         bus.req);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        bus.req = '0;
        bus.din = '0;
        test_reset();
        test_single();
        test_contention();
        test_early_drop();
        test_priority();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
